// File: rtl/gen_ram_fifo_2p.sv
// Two-port RAM FIFO with a registered prefetch stage giving first-word-fall-through output.
// Latency: a word pushed into an empty FIFO is presented on readValid two cycles later.
// Backpressure: writeReady comes from a flop (count < DEPTH); readReady stalls hold readData/readValid.
module gen_ram_fifo_2p #(
    parameter int WIDTH      = 116,
    parameter int ADDR_WIDTH = 8,
    parameter int AFULL_TH   = 252,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clockCore,
    input  logic                  resetCore,
    input  logic                  flush,
    input  logic                  writeValid,
    output logic                  writeReady,
    input  logic [WIDTH-1:0]      writeData,
    output logic                  readValid,
    input  logic                  readReady,
    output logic [WIDTH-1:0]      readData,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

    logic [WIDTH-1:0]    mem [DEPTH];

    // Pointers carry one extra bit so RAM occupancy (wr - rd) is unambiguous.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                out_vld_q, out_vld_d;
    logic                wr_rdy_q, wr_rdy_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH-1:0]    rd_dat_q;

    logic                push;
    logic                pop;
    logic                ram_has_word;
    logic                ram_rd_en;

    // Handshakes; anything coincident with flush is dropped.
    assign push         = writeValid & wr_rdy_q & ~flush;
    assign pop          = out_vld_q & readReady & ~flush;
    assign ram_has_word = (wr_ptr_q != rd_ptr_q);
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign ram_rd_en    = ram_has_word & (~out_vld_q | pop) & ~flush;

    // Next-state for pointers, occupancy, output-valid and status flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        out_vld_d = out_vld_q;
        wr_rdy_d  = wr_rdy_q;
        afull_d   = afull_q;
        aempty_d  = aempty_q;
        ovf_d     = ovf_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
            wr_rdy_d  = 1'b1;
            afull_d   = 1'b0;
            aempty_d  = 1'b1;
            ovf_d     = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (ram_rd_en) begin
                rd_ptr_d  = rd_ptr_q + ONE_C;
                out_vld_d = 1'b1;
            end else if (pop) begin
                out_vld_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            // Flags are registered from next count so they track count exactly.
            wr_rdy_d = (count_d < DEPTH_C);
            afull_d  = (count_d >= AFULL_C);
            aempty_d = (count_d <= AEMPTY_C);
            ovf_d    = ovf_q | (writeValid & ~wr_rdy_q);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            wr_rdy_q  <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            wr_rdy_q  <= wr_rdy_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
        end
    end

    // RAM write port; contents are never cleared.
    always_ff @(posedge clockCore) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= writeData;
        end
    end

    // RAM registered read port doubling as the prefetch output register; holds when not refilled.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            rd_dat_q <= '0;
        end else if (ram_rd_en) begin
            rd_dat_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign writeReady  = wr_rdy_q;
    assign readValid   = out_vld_q;
    assign readData    = rd_dat_q;
    assign count       = count_q;
    assign almostFull  = afull_q;
    assign almostEmpty = aempty_q;
    assign overflow    = ovf_q;

endmodule
